// File: rtl/tia_playfield_pkg.sv
// Shared types and sizing helpers for the playfield serializer.
package tia_playfield_pkg;
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} pf_state_e;

  localparam int PF_BITS_DEFAULT      = 20;
  localparam int CLKS_PER_BIT_DEFAULT = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tia_playfield_prescaler.sv
// Wrap counter 0..N-1 with clear; terminal flags the last clock of a bit.
module tia_playfield_prescaler
  import tia_playfield_pkg::*;
#(
  parameter int N = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic terminal
);
  localparam int W = cnt_w(N);

  logic [W-1:0] cnt;

  assign terminal = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)  cnt <= '0;
    else if (en)       cnt <= terminal ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/tia_playfield_serializer.sv
// Serializes a playfield pattern over a left half and a repeated/mirrored right half.
module tia_playfield_serializer
  import tia_playfield_pkg::*;
#(
  parameter int PF_BITS      = PF_BITS_DEFAULT,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PF_BITS-1:0] pf_data,
  input  logic               pf_load,
  input  logic               line_start,
  input  logic               reflect,
  output logic               pf_out,
  output logic               pf_active,
  output logic               pf_right
);
  localparam int IW = cnt_w(PF_BITS);

  pf_state_e          state, state_n;
  logic [IW-1:0]      idx, idx_n;
  logic [PF_BITS-1:0] pattern;
  logic               refl_q, refl_n;
  logic               step, last_bit, half_sw, pixel;

  tia_playfield_prescaler #(.N(CLKS_PER_BIT)) u_presc (
    .clk      (clk),
    .reset    (reset),
    .clr      (line_start | half_sw),
    .en       (state != IDLE),
    .terminal (step)
  );

  assign last_bit = step && (idx == IW'(PF_BITS - 1));
  assign half_sw  = (state == LEFT) && last_bit;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    refl_n  = refl_q;
    case (state)
      LEFT: if (last_bit) begin
        state_n = RIGHT;
        idx_n   = '0;
        refl_n  = reflect;
      end else if (step) begin
        idx_n = idx + 1'b1;
      end
      RIGHT: if (last_bit) begin
        state_n = IDLE;
        idx_n   = '0;
      end else if (step) begin
        idx_n = idx + 1'b1;
      end
      default: ;
    endcase
    // A new line always restarts from the leftmost pixel.
    if (line_start) begin
      state_n = LEFT;
      idx_n   = '0;
    end
  end

  always_comb begin
    pixel = 1'b0;
    case (state)
      LEFT:    pixel = pattern[idx];
      RIGHT:   pixel = refl_q ? pattern[IW'(PF_BITS - 1) - idx] : pattern[idx];
      default: pixel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      refl_q    <= 1'b0;
      pattern   <= '0;
      pf_out    <= 1'b0;
      pf_active <= 1'b0;
      pf_right  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      refl_q    <= refl_n;
      if (pf_load) pattern <= pf_data;
      pf_out    <= pixel;
      pf_active <= (state != IDLE);
      pf_right  <= (state == RIGHT);
    end
  end
endmodule

// File: tb/tb_tia_playfield_serializer.sv
// Bench: scan-position model checked every cycle, plus literal checks of the directed scans.
module tb_tia_playfield_serializer;
  localparam int PF  = 20;
  localparam int CPB = 4;
  localparam int H   = PF * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b0, pf_load = 1'b0, line_start = 1'b0, reflect = 1'b0;
  logic [PF-1:0] pf_data = '0;
  logic          pf_out, pf_active, pf_right;

  int total = 0, bad = 0;

  tia_playfield_serializer #(.PF_BITS(PF), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .pf_data(pf_data), .pf_load(pf_load),
    .line_start(line_start), .reflect(reflect),
    .pf_out(pf_out), .pf_active(pf_active), .pf_right(pf_right)
  );

  always #5 clk = ~clk;

  // Model: t = clocks since the scan began (-1 when idle).
  int            t = -1;
  logic [PF-1:0] m_pat = '0;
  bit            m_refl = 0, mv = 0;
  bit            e_out = 0, e_act = 0, e_right = 0;

  always @(posedge clk) begin
    int b;
    if (reset) begin
      t = -1; m_pat = '0; m_refl = 0; mv = 1;
      e_out = 0; e_act = 0; e_right = 0;
    end else begin
      e_act   = (t >= 0);
      e_right = (t >= H);
      e_out   = 0;
      if (t >= 0) begin
        b = (t % H) / CPB;
        if (t >= H && m_refl) e_out = m_pat[PF-1-b];
        else                  e_out = m_pat[b];
      end
      if (line_start) t = 0;
      else if (t >= 0) begin
        t = t + 1;
        if (t == H) m_refl = reflect;
        if (t == 2 * H) t = -1;
      end
      if (pf_load) m_pat = pf_data;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      total++;
      if ({pf_out, pf_active, pf_right} !== {e_out, e_act, e_right}) begin
        bad++;
        $display("FAIL model t=%0d out/act/right got=%b%b%b want=%b%b%b", t,
                 pf_out, pf_active, pf_right, e_out, e_act, e_right);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic load(input logic [PF-1:0] v);
    pf_load = 1; pf_data = v; step(); pf_load = 0;
  endtask

  int ho[0:255], ha[0:255], hr[0:255];

  function automatic int ones(input int lo, input int hi, input int which);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      n += (which == 0) ? ho[i] : (which == 1) ? ha[i] : hr[i];
    return n;
  endfunction

  // Edge 0 carries line_start; outputs recorded after edge e are cycle e.
  task automatic scan(input bit refl0, input int n, input int load_e,
                      input logic [PF-1:0] load_v, input int rst_e,
                      input int rs_e, input int flip_e);
    for (int e = 0; e <= n; e++) begin
      line_start = (e == 0 || e == rs_e);
      pf_load    = (e == load_e);
      pf_data    = load_v;
      reset      = (e == rst_e);
      reflect    = (flip_e > 0 && e >= flip_e) ? ~refl0 : refl0;
      step();
      ho[e] = pf_out; ha[e] = pf_active; hr[e] = pf_right;
    end
    line_start = 0; pf_load = 0; reset = 0;
  endtask

  initial begin
    reset = 1; step(); reset = 0;
    chk("reset_out", pf_out, 0);
    chk("reset_active", pf_active, 0);
    chk("reset_right", pf_right, 0);

    load(20'h00001);
    scan(0, 170, -1, 0, -1, -1, 0);
    chk("t1_first", ones(1, 4, 0), 4);
    chk("t1_gap", ones(5, 80, 0), 0);
    chk("t1_right", ones(81, 84, 0), 4);
    chk("t1_tail", ones(85, 170, 0), 0);
    chk("t1_right80", hr[80], 0);
    chk("t1_right81", hr[81], 1);

    scan(1, 170, -1, 0, -1, -1, 0);
    chk("t2_first", ones(1, 4, 0), 4);
    chk("t2_mid", ones(5, 156, 0), 0);
    chk("t2_mirror", ones(157, 160, 0), 4);
    chk("t2_act160", ha[160], 1);
    chk("t2_act161", ha[161], 0);

    load(20'hFFFFF);
    scan(0, 170, -1, 0, -1, -1, 0);
    chk("t3_out", ones(1, 160, 0), 160);
    chk("t3_act", ones(1, 160, 1), 160);
    chk("t3_after", ones(161, 170, 0) + ones(161, 170, 1) + ones(161, 170, 2), 0);
    chk("t3_c0", ho[0], 0);

    load(20'h00000);
    scan(0, 170, 5, 20'h00002, -1, -1, 0);
    chk("t4_before", ones(1, 5, 0), 0);
    chk("t4_bit1", ones(6, 8, 0), 3);
    chk("t4_c9", ho[9], 0);
    chk("t4_right", ones(85, 88, 0), 4);
    chk("t4_total", ones(0, 170, 0), 7);

    load(20'h00001);
    scan(0, 215, -1, 20'h00001, -1, 50, 0);
    chk("t5_first", ones(1, 4, 0), 4);
    chk("t5_restart", ones(51, 54, 0), 4);
    chk("t5_old_right", ho[81], 0);
    chk("t5_new_right", ones(131, 134, 0), 4);
    chk("t5_act", ones(1, 210, 1), 210);
    chk("t5_act211", ha[211], 0);

    scan(0, 40, -1, 20'h00001, 31, -1, 0);
    chk("t6_act30", ha[30], 1);
    chk("t6_out31", ho[31], 0);
    chk("t6_act31", ha[31], 0);
    scan(0, 170, -1, 0, -1, -1, 0);
    chk("t6_cleared", ones(0, 170, 0), 0);
    chk("t6_act", ones(1, 160, 1), 160);
    load(20'h00001);
    scan(0, 170, -1, 0, -1, -1, 100);
    chk("t6_flip_repeat", ones(81, 84, 0), 4);
    chk("t6_flip_nomirror", ones(157, 160, 0), 0);

    for (int i = 0; i < 5000; i++) begin
      reset      = ($urandom_range(0, 599) == 0);
      line_start = ($urandom_range(0, 149) == 0);
      pf_load    = ($urandom_range(0, 19) == 0);
      pf_data    = PF'($urandom);
      if ($urandom_range(0, 29) == 0) reflect = ~reflect;
      step();
    end
    reset = 0; line_start = 0; pf_load = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
